// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: turns one command into one
// bus cycle and returns a response, aborting with an error after a wait-state timeout.
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state;
  logic        r_cmd_ready, w_cmd_ready;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_rsp_err, w_rsp_err;
  logic [31:0] r_rsp_data, w_rsp_data;
  logic        r_cyc, w_cyc;
  logic        r_stb, w_stb;
  logic        r_we, w_we;
  logic [3:0]  r_sel, w_sel;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_data, w_data;
  logic [15:0] r_cnt, w_cnt;

  // reset is active-low; every output, including the bus payload, returns to zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_data  <= w_rsp_data;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_sel       <= w_sel;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_rsp_data  = r_rsp_data;
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_we        = r_we;
    w_sel       = r_sel;
    w_addr      = r_addr;
    w_data      = r_data;
    w_cnt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          w_we        = cmd_we;
          w_addr      = cmd_addr;
          w_data      = cmd_data;
          w_sel       = cmd_sel;
          w_cyc       = 1'b1;
          w_stb       = 1'b1;
          w_cnt       = '0;
          w_state     = S_BUS;
        end
      end
      S_BUS: begin
        // an ack on the last permitted cycle still completes normally
        if (i_wb_ack) begin
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b0;
          w_rsp_data  = r_we ? 32'd0 : i_wb_data;
          w_state     = S_RESP;
        end else if (r_cnt == LP_LAST) begin
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_data  = 32'd0;
          w_state     = S_RESP;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = S_IDLE;
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b0;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_sel  = r_sel;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_data;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: table of commands with responder behaviour and expected
// responses, scoreboard queue, plus hand-written reset and idle-ack sequences.
module tb_wb_initiator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic [31:0] i_wb_data = '0;

  wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 clock = ~clock;

  // ack_cyc = stb cycle on which the responder acks (0 = never); hold = rsp_ready-low cycles
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          ack_cyc;
    logic [31:0] ack_data;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[6];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cnt;
    int   guard;
    exp_t e;
    guard = 0;
    while (!cmd_ready && guard < 20) begin tick(); guard++; end
    chk($sformatf("v%0d_cmd_ready_idle", idx), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_data = v.data; cmd_sel = v.sel;
    tick();
    cmd_valid = 1'b0;
    sb.push_back('{v.exp_err, v.exp_data});
    chk($sformatf("v%0d_cmd_ready_bus", idx), {31'd0, cmd_ready}, 32'd0);
    cnt = 0;
    guard = 0;
    while (o_wb_cyc && guard < 50) begin
      cnt++;
      chk($sformatf("v%0d_stb_c%0d", idx, cnt), {31'd0, o_wb_stb}, 32'd1);
      chk($sformatf("v%0d_addr_c%0d", idx, cnt), o_wb_addr, v.addr);
      chk($sformatf("v%0d_wdata_c%0d", idx, cnt), o_wb_data, v.data);
      chk($sformatf("v%0d_wesel_c%0d", idx, cnt), {27'd0, o_wb_we, o_wb_sel}, {27'd0, v.we, v.sel});
      chk($sformatf("v%0d_rspv_in_bus", idx), {31'd0, rsp_valid}, 32'd0);
      if (cnt == v.ack_cyc) begin i_wb_ack = 1'b1; i_wb_data = v.ack_data; end
      tick();
      i_wb_ack = 1'b0;
      guard++;
    end
    chk($sformatf("v%0d_cyc_cycles", idx), cnt, v.exp_cyc);
    chk($sformatf("v%0d_stb_low", idx), {31'd0, o_wb_stb}, 32'd0);
    chk($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, e.err});
    chk($sformatf("v%0d_rsp_data", idx), rsp_data, e.data);
    // backpressure: a late ack and a competing command must both be ignored
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h5555_0000; i_wb_ack = 1'b1; i_wb_data = 32'hBAD0_BAD0;
      tick();
      chk($sformatf("v%0d_hold%0d_stable", idx, h), {rsp_valid, rsp_err, cmd_ready, o_wb_cyc},
          {1'b1, e.err, 1'b0, 1'b0});
      chk($sformatf("v%0d_hold%0d_data", idx, h), rsp_data, e.data);
    end
    i_wb_ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_rsp_cleared", idx), {30'd0, rsp_valid, o_wb_cyc}, 32'd0);
    chk($sformatf("v%0d_ready_again", idx), {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h1111_1111, 0, 1'b0, 32'h0, 1};
    tbl[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 4, 32'h0000_00A5, 1, 1'b0, 32'hA5, 4};
    tbl[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 0, 32'h0,         2, 1'b1, 32'h0, 8};
    tbl[3] = '{1'b0, 32'h3000_0024, 32'h0,         4'hF, 8, 32'h1234_5678, 1, 1'b0, 32'h1234_5678, 8};
    tbl[4] = '{1'b1, 32'h3000_0028, 32'h0BAD_F00D, 4'h5, 3, 32'hFFFF_FFFF, 5, 1'b0, 32'h0, 3};
    tbl[5] = '{1'b0, 32'h3000_002C, 32'h0,         4'h3, 2, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 2};

    #12;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_outs", {29'd0, rsp_valid, rsp_err, o_wb_cyc}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_wb_addr", o_wb_addr, 32'd0);
    chk("reset_wb_misc", {26'd0, o_wb_stb, o_wb_we, o_wb_sel}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // ack while idle changes nothing
    i_wb_ack = 1'b1; i_wb_data = 32'h7777_7777;
    tick();
    i_wb_ack = 1'b0;
    chk("idle_ack_ignored", {29'd0, o_wb_cyc, rsp_valid, cmd_ready}, 32'd1);

    // reset in the middle of a wait-stated bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0040; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre_reset_cyc", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
    #3 reset = 1'b0;
    #1;
    chk("async_reset_cyc", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    chk("async_reset_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    chk("async_reset_addr", o_wb_addr, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("post_reset_ready", {29'd0, cmd_ready, rsp_valid, o_wb_cyc}, 32'd4);
    tick(); tick();
    chk("no_rsp_after_abort", {30'd0, rsp_valid, o_wb_cyc}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    // one more command after the abort completes normally
    run_vec(tbl[5], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
